// File: rtl/complement_arbiter.sv
// complement_arbiter
//   Shares one WIDTH-bit two's-complement (negation) unit between two
//   requesters: requester 0 (SUB-operand path) and requester 1 (branch
//   compare/offset path). Round-robin arbitration in IDLE, one registered
//   compute stage, one transaction in flight at a time.
//
// Ports
//   CLK          rising-edge clock
//   RESET        synchronous, active-low reset
//   req0_valid   requester 0 has an operand
//   req0_data    requester 0 operand
//   req0_ready   requester 0 operand accepted this cycle
//   req1_valid   requester 1 has an operand
//   req1_data    requester 1 operand
//   req1_ready   requester 1 operand accepted this cycle
//   resp0_valid  result available for requester 0
//   resp0_ready  requester 0 consumes result
//   resp1_valid  result available for requester 1
//   resp1_ready  requester 1 consumes result
//   resp_data    negated operand, shared by both requesters
//   resp_ovf     operand was the most-negative value
//   busy         FSM not in IDLE
module complement_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             r_owner;
    logic [WIDTH-1:0] r_op;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_ovf;
    logic             w_grant;
    logic             w_accept;

    function automatic logic [WIDTH-1:0] f_negate(input logic [WIDTH-1:0] op);
        return ~op + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The most-negative value is its own negation; flag it.
    function automatic logic f_is_min(input logic [WIDTH-1:0] op);
        return op == {1'b1, {(WIDTH-1){1'b0}}};
    endfunction

    // Lone requester wins; under contention the one not served last wins.
    always_comb begin
        w_grant = req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant = ~r_last;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req0_ready = req0_valid && !w_grant;
                req1_ready = req1_valid && w_grant;
                w_accept   = req0_valid || req1_valid;
                if (w_accept) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp0_valid = !r_owner;
                resp1_valid = r_owner;
                if ((!r_owner && resp0_ready) || (r_owner && resp1_ready)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_resp_data <= '0;
            r_resp_ovf  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_last <= w_grant;
            end
            // Result only moves on the CALC->RESP edge, so it is frozen in RESP.
            if (r_state == ST_CALC) begin
                r_resp_data <= f_negate(r_op);
                r_resp_ovf  <= f_is_min(r_op);
            end
        end
    end

    // Operand and owner are only meaningful after an acceptance; no reset needed.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_op    <= w_grant ? req1_data : req0_data;
            r_owner <= w_grant;
        end
    end

    assign resp_data = r_resp_data;
    assign resp_ovf  = r_resp_ovf;
    assign busy      = (r_state != ST_IDLE);

endmodule
